csa_sub_seq_16: RTL and testbench

CSA_SUB_SEQ_16 -- requirements
Module: csa_sub_seq_16

---
 rtl/csa_sub_seq_16_if.sv | 23 ++
 rtl/csa_sub_seq_16.sv | 86 ++++++++
 tb/tb_csa_sub_seq_16.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/csa_sub_seq_16_if.sv
// csa_sub_seq_16_if: request, operand and result bundle for csa_sub_seq_16
interface csa_sub_seq_16_if #(
   parameter int WIDTH = 16
);
   logic             i_start;
   logic             i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_result;
   logic             o_c_out;
   logic             o_ovf;
   logic             o_zero;
   modport master (
      output i_start, i_op, i_a, i_b,
      input  o_busy, o_done, o_result, o_c_out, o_ovf, o_zero
   );
   modport slave (
      input  i_start, i_op, i_a, i_b,
      output o_busy, o_done, o_result, o_c_out, o_ovf, o_zero
   );
endinterface

// File: rtl/csa_sub_seq_16.sv
// csa_sub_seq_16: slice-serial adder/subtractor, SLICE bits per clock, LSB slice first
module csa_sub_seq_16 #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic             clk,
   input logic             rst_n,
   csa_sub_seq_16_if.slave s_if
);
   localparam int NSL = WIDTH / SLICE;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t                 r_state;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-1:0]       r_result;
   logic [WIDTH-SLICE-1:0] r_sum;
   logic [CW-1:0]          r_cnt;
   logic                   r_op;
   logic                   r_carry;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_c_out;
   logic                   r_ovf;
   logic                   r_zero;
   logic [SLICE:0]         w_sum;
   logic [WIDTH-1:0]       w_full;
   logic                   w_last;
   logic                   w_accept;
   // operands shift right each slice, so the active slice is always the low bits
   assign w_sum    = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + {{SLICE{1'b0}}, r_carry};
   assign w_full   = {w_sum[SLICE-1:0], r_sum};
   assign w_last   = r_cnt == CW'(NSL - 1);
   assign w_accept = s_if.i_start && (r_state != BUSY);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_op     <= 1'b0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_state <= BUSY;
            r_busy  <= 1'b1;
            r_a     <= s_if.i_a;
            r_b     <= s_if.i_op ? ~s_if.i_b : s_if.i_b;
            r_op    <= s_if.i_op;
            r_cnt   <= '0;
            r_carry <= s_if.i_op;
         end else if (r_state == BUSY) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_sum   <= {w_sum[SLICE-1:0], r_sum[WIDTH-SLICE-1:SLICE]};
            r_carry <= w_sum[SLICE];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               r_state  <= DONE;
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_result <= w_full;
               r_c_out  <= w_sum[SLICE] ^ r_op;
               r_ovf    <= (r_a[SLICE-1] == r_b[SLICE-1]) && (w_full[WIDTH-1] != r_a[SLICE-1]);
               r_zero   <= ~|w_full;
            end
         end else begin
            r_state <= IDLE;
         end
      end
   end
   assign s_if.o_busy   = r_busy;
   assign s_if.o_done   = r_done;
   assign s_if.o_result = r_result;
   assign s_if.o_c_out  = r_c_out;
   assign s_if.o_ovf    = r_ovf;
   assign s_if.o_zero   = r_zero;
endmodule

// File: tb/tb_csa_sub_seq_16.sv
// tb_csa_sub_seq_16: directed tests for the slice-serial adder/subtractor
module tb_csa_sub_seq_16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   csa_sub_seq_16_if #(.WIDTH(16)) bus ();
   csa_sub_seq_16 #(.WIDTH(16), .SLICE(4)) dut (.clk(clk), .rst_n(rst_n), .s_if(bus));

   // called on a negedge with the DUT idle or in DONE; flags are {c_out, ovf, zero}
   task automatic run_op(input string name, input logic op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_res, input logic [2:0] e_flg);
      int lat;
      int bcnt;
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_op    = ~op;
      bus.i_a     = ~a;
      bus.i_b     = a ^ b;
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", name, bus.o_busy, bus.o_done);
      end
      lat  = 0;
      bcnt = 0;
      while (bus.o_done !== 1'b1 && lat < 20) begin
         if (bus.o_busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL %s latency: got %0d want 4", name, lat);
      end
      checks++;
      if (bcnt != 4 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d (busy at done=%b) want 4 (0)", name, bcnt, bus.o_busy);
      end
      checks++;
      if (bus.o_result !== e_res) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, bus.o_result, e_res);
      end
      checks++;
      if ({bus.o_c_out, bus.o_ovf, bus.o_zero} !== e_flg) begin
         errors++;
         $display("FAIL %s flags(c,v,z): got %b want %b", name, {bus.o_c_out, bus.o_ovf, bus.o_zero}, e_flg);
      end
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0 || bus.o_result !== e_res) begin
         errors++;
         $display("FAIL %s hold: done=%b result=%h want done=0 result=%h", name, bus.o_done, bus.o_result, e_res);
      end
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({bus.o_busy, bus.o_done, bus.o_result, bus.o_c_out, bus.o_ovf, bus.o_zero} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
                  bus.o_busy, bus.o_done, bus.o_result, bus.o_c_out, bus.o_ovf, bus.o_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      run_op("add", 1'b0, 16'h1234, 16'h4321, 16'h5555, 3'b000);
   endtask

   task automatic test_borrow;
      run_op("borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 3'b100);
   endtask

   task automatic test_overflow;
      run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
      run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 3'b010);
   endtask

   task automatic test_wrap_zero;
      run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 3'b101);
      run_op("sub_zero", 1'b1, 16'hABCD, 16'hABCD, 16'h0000, 3'b001);
   endtask

   task automatic test_ignore_start;
      int lat;
      bit seen_busy;
      bus.i_start = 1'b1;
      bus.i_op    = 1'b0;
      bus.i_a     = 16'h1234;
      bus.i_b     = 16'h4321;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op    = 1'b1;
      bus.i_a     = 16'hFFFF;
      bus.i_b     = 16'h0F0F;
      @(negedge clk);
      bus.i_start = 1'b0;
      lat = 2;
      while (bus.o_done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 4 || bus.o_result !== 16'h5555) begin
         errors++;
         $display("FAIL ignore_start: latency=%0d result=%h want 4 5555", lat, bus.o_result);
      end
      seen_busy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) seen_busy = 1'b1;
      end
      checks++;
      if (seen_busy || bus.o_result !== 16'h5555) begin
         errors++;
         $display("FAIL ignore_restart: activity=%b result=%h want 0 5555", seen_busy, bus.o_result);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      bus.i_start = 1'b1;
      bus.i_op    = 1'b0;
      bus.i_a     = 16'h0001;
      bus.i_b     = 16'h0002;
      @(negedge clk);
      bus.i_op = 1'b1;
      bus.i_a  = 16'h0010;
      bus.i_b  = 16'h0001;
      lat = 0;
      while (bus.o_done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 4 || bus.o_result !== 16'h0003 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: latency=%0d result=%h busy=%b want 4 0003 0", lat, bus.o_result, bus.o_busy);
      end
      run_op("b2b_second", 1'b1, 16'h0010, 16'h0001, 16'h000F, 3'b000);
   endtask

   task automatic test_reset_mid_op;
      bit seen_done;
      bus.i_start = 1'b1;
      bus.i_op    = 1'b0;
      bus.i_a     = 16'h1234;
      bus.i_b     = 16'h4321;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.o_busy, bus.o_done, bus.o_result, bus.o_c_out, bus.o_ovf, bus.o_zero} !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_op: got busy=%b done=%b result=%h c=%b v=%b z=%b want all 0",
                  bus.o_busy, bus.o_done, bus.o_result, bus.o_c_out, bus.o_ovf, bus.o_zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL reset_abort: activity after reset got 1 want 0");
      end
      run_op("after_reset", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_op    = 1'b0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      test_reset();
      test_add();
      test_borrow();
      test_overflow();
      test_wrap_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
